// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the stdout 7-segment display converter.
//   - estado_t       : converter FSM states
//   - SEG_*          : active-low segment codes, bit order {a,b,c,d,e,f,g}
//   - corrige_nibble : double-dabble add-3 correction of one BCD nibble
package display_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        CONVERTE,
        ATUALIZA
    } estado_t;

    localparam logic [6:0] SEG_APAGADO = 7'b1111111;
    localparam logic [6:0] SEG_TRACO   = 7'b1111110;
    localparam logic [6:0] SEG_0       = 7'b0000001;
    localparam logic [6:0] SEG_1       = 7'b1001111;
    localparam logic [6:0] SEG_2       = 7'b0010010;
    localparam logic [6:0] SEG_3       = 7'b0000110;
    localparam logic [6:0] SEG_4       = 7'b1001100;
    localparam logic [6:0] SEG_5       = 7'b0100100;
    localparam logic [6:0] SEG_6       = 7'b0100000;
    localparam logic [6:0] SEG_7       = 7'b0001111;
    localparam logic [6:0] SEG_8       = 7'b0000000;
    localparam logic [6:0] SEG_9       = 7'b0000100;

    // A nibble of 5 or more would exceed 9 after the next shift; adding 3
    // first makes the shift carry into the next decimal digit.
    function automatic logic [3:0] corrige_nibble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/decod_7seg.sv
// decod_7seg: BCD digit to active-low 7-segment code.
//   bcd : 4-bit BCD digit in (values above 9 show blank)
//   seg : segments {a,b,c,d,e,f,g}, 0 = lit
module decod_7seg
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_APAGADO;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_APAGADO;
        endcase
    end

endmodule

// File: rtl/conversor_display.sv
// conversor_display: captures the CPU stdout value and shows it in decimal on
// two active-low 7-segment digits (tens, units). Binary-to-BCD uses an
// iterative double-dabble, one bit per clock. Values >= 100 show two dashes.
//
// Ports:
//   clk_rapido        : clock, rising edge
//   reset             : synchronous active-high reset
//   stdout_7b         : value to display (LARGURA bits)
//   stdout_we         : write strobe, accepted while pronto=1
//   pronto            : idle, a write is accepted this cycle
//   descartado        : one-cycle pulse after a write arrived while busy
//   dez_a..dez_g      : tens digit segments, active-low
//   unid_a..unid_g    : units digit segments, active-low
//
// Build option: define APAGA_ZERO_ESQ_EN to blank a leading zero in the tens
// digit.
module conversor_display
    import display_pkg::*;
#(
    parameter int LARGURA = 7
) (
    input  logic               clk_rapido,
    input  logic               reset,
    input  logic [LARGURA-1:0] stdout_7b,
    input  logic               stdout_we,
    output logic               pronto,
    output logic               descartado,
    output logic               dez_a,
    output logic               dez_b,
    output logic               dez_c,
    output logic               dez_d,
    output logic               dez_e,
    output logic               dez_f,
    output logic               dez_g,
    output logic               unid_a,
    output logic               unid_b,
    output logic               unid_c,
    output logic               unid_d,
    output logic               unid_e,
    output logic               unid_f,
    output logic               unid_g
);

    localparam int CW = $clog2(LARGURA + 1);

    estado_t            estado;
    estado_t            prox_estado;
    logic [LARGURA-1:0] desloc;
    logic [11:0]        bcd;
    logic [11:0]        bcd_corr;
    logic [CW-1:0]      contador;
    logic [6:0]         seg_dez;
    logic [6:0]         seg_unid;
    logic [6:0]         dec_dez;
    logic [6:0]         dec_unid;

    // State register
    always_ff @(posedge clk_rapido) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next-state logic
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:   if (stdout_we) prox_estado = CONVERTE;
            CONVERTE: if (contador == CW'(1)) prox_estado = ATUALIZA;
            ATUALIZA: prox_estado = OCIOSO;
            default:  prox_estado = OCIOSO;
        endcase
    end

    assign pronto = (estado == OCIOSO);

    assign bcd_corr = {corrige_nibble(bcd[11:8]),
                       corrige_nibble(bcd[7:4]),
                       corrige_nibble(bcd[3:0])};

    decod_7seg u_dec_dez  (.bcd(bcd[7:4]), .seg(dec_dez));
    decod_7seg u_dec_unid (.bcd(bcd[3:0]), .seg(dec_unid));

    // Datapath: shift/BCD registers, segment registers, discard pulse
    always_ff @(posedge clk_rapido) begin
        if (reset) begin
            desloc     <= '0;
            bcd        <= '0;
            contador   <= '0;
            seg_dez    <= SEG_APAGADO;
            seg_unid   <= SEG_APAGADO;
            descartado <= 1'b0;
        end else begin
            descartado <= stdout_we && (estado != OCIOSO);
            case (estado)
                OCIOSO: begin
                    if (stdout_we) begin
                        desloc   <= stdout_7b;
                        bcd      <= '0;
                        contador <= CW'(LARGURA);
                    end
                end
                CONVERTE: begin
                    // {bcd,desloc} shifted left as one wide register
                    bcd      <= {bcd_corr[10:0], desloc[LARGURA-1]};
                    desloc   <= {desloc[LARGURA-2:0], 1'b0};
                    contador <= contador - CW'(1);
                end
                ATUALIZA: begin
                    if (bcd[11:8] != 4'd0) begin
                        seg_dez  <= SEG_TRACO;
                        seg_unid <= SEG_TRACO;
                    end else begin
`ifdef APAGA_ZERO_ESQ_EN
                        seg_dez  <= (bcd[7:4] == 4'd0) ? SEG_APAGADO : dec_dez;
`else
                        seg_dez  <= dec_dez;
`endif
                        seg_unid <= dec_unid;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {dez_a, dez_b, dez_c, dez_d, dez_e, dez_f, dez_g}        = seg_dez;
    assign {unid_a, unid_b, unid_c, unid_d, unid_e, unid_f, unid_g} = seg_unid;

endmodule

// File: tb/tb_conversor_display.sv
// Self-checking bench for conversor_display: scoreboard of expected digit
// pairs pushed on each accepted write, popped when the conversion completes.
module tb_conversor_display;

    localparam int LARGURA = 7;

    logic               clk_rapido = 1'b0;
    logic               reset      = 1'b1;
    logic [LARGURA-1:0] stdout_7b  = '0;
    logic               stdout_we  = 1'b0;
    logic               pronto;
    logic               descartado;
    logic dez_a, dez_b, dez_c, dez_d, dez_e, dez_f, dez_g;
    logic unid_a, unid_b, unid_c, unid_d, unid_e, unid_f, unid_g;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [13:0] exp_q[$];

    always #5 clk_rapido = ~clk_rapido;

    conversor_display #(.LARGURA(LARGURA)) dut (
        .clk_rapido(clk_rapido), .reset(reset),
        .stdout_7b(stdout_7b), .stdout_we(stdout_we),
        .pronto(pronto), .descartado(descartado),
        .dez_a(dez_a), .dez_b(dez_b), .dez_c(dez_c), .dez_d(dez_d),
        .dez_e(dez_e), .dez_f(dez_f), .dez_g(dez_g),
        .unid_a(unid_a), .unid_b(unid_b), .unid_c(unid_c), .unid_d(unid_d),
        .unid_e(unid_e), .unid_f(unid_f), .unid_g(unid_g)
    );

    wire [6:0] dez  = {dez_a, dez_b, dez_c, dez_d, dez_e, dez_f, dez_g};
    wire [6:0] unid = {unid_a, unid_b, unid_c, unid_d, unid_e, unid_f, unid_g};

    function automatic logic [6:0] codigo(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected {dez,unid} for a written value
    function automatic logic [13:0] esperado(input int v);
        logic [6:0] d;
        if (v >= 100) return {7'b1111110, 7'b1111110};
        d = codigo(v / 10);
`ifdef APAGA_ZERO_ESQ_EN
        if (v / 10 == 0) d = 7'b1111111;
`endif
        return {d, codigo(v % 10)};
    endfunction

    // Drive a one-cycle strobe; returns at the negedge after the accepting edge.
    task automatic escreve(input int v, input bit registra);
        @(negedge clk_rapido);
        stdout_7b = LARGURA'(v);
        stdout_we = 1'b1;
        if (registra) exp_q.push_back(esperado(v));
        @(negedge clk_rapido);
        stdout_we = 1'b0;
    endtask

    // Wait (bounded) for pronto to return; timeout flag reported to caller.
    task automatic espera_fim(output bit expirou);
        expirou = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_rapido);
            if (pronto === 1'b1) begin
                expirou = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int pulsos;
        reset = 1'b1;
        repeat (3) @(negedge clk_rapido);
        reset = 1'b0;
        pulsos = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_rapido);
            if (descartado !== 1'b0) pulsos++;
        end
        tests_run++;
        if (pronto !== 1'b1) begin
            tests_failed++; $display("FAIL reset_pronto got %b want 1", pronto);
        end
        tests_run++;
        if ({dez, unid} !== {7'b1111111, 7'b1111111}) begin
            tests_failed++; $display("FAIL reset_digits got %b %b want 1111111 1111111", dez, unid);
        end
        tests_run++;
        if (pulsos != 0) begin
            tests_failed++; $display("FAIL reset_descartado got %0d pulses want 0", pulsos);
        end
        // reset asserted together with a write: write must be dropped
        @(negedge clk_rapido);
        reset = 1'b1; stdout_we = 1'b1; stdout_7b = LARGURA'(55);
        @(negedge clk_rapido);
        reset = 1'b0; stdout_we = 1'b0;
        tests_run++;
        if (pronto !== 1'b1) begin
            tests_failed++; $display("FAIL reset_with_we_pronto got %b want 1", pronto);
        end
    endtask

    task automatic test_latency;
        logic [13:0] exp;
        bit ok;
        escreve(42, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < LARGURA; i++) begin
            @(negedge clk_rapido);
            if (pronto !== 1'b0 || {dez, unid} !== {7'b1111111, 7'b1111111}) ok = 1'b0;
        end
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL latency_hold got %b %b pronto %b want blank while busy", dez, unid, pronto);
        end
        @(negedge clk_rapido);
        exp = exp_q.pop_front();
        tests_run++;
        if ({dez, unid} !== exp) begin
            tests_failed++; $display("FAIL latency_42 got %b %b want %b %b", dez, unid, exp[13:7], exp[6:0]);
        end
        tests_run++;
        if (pronto !== 1'b1) begin
            tests_failed++; $display("FAIL latency_pronto got %b want 1", pronto);
        end
    endtask

    task automatic test_values;
        int vals[6] = '{7, 99, 0, 100, 127, 58};
        logic [13:0] exp;
        bit expirou;
        foreach (vals[k]) begin
            escreve(vals[k], 1'b1);
            espera_fim(expirou);
            exp = exp_q.pop_front();
            tests_run++;
            if (expirou) begin
                tests_failed++; $display("FAIL value_%0d timeout waiting for pronto", vals[k]);
            end else if ({dez, unid} !== exp) begin
                tests_failed++; $display("FAIL value_%0d got %b %b want %b %b", vals[k], dez, unid, exp[13:7], exp[6:0]);
            end
        end
    endtask

    task automatic test_busy_write;
        logic [13:0] exp;
        bit expirou;
        escreve(42, 1'b1);
        @(negedge clk_rapido);
        stdout_7b = LARGURA'(13); stdout_we = 1'b1;
        @(negedge clk_rapido);
        stdout_we = 1'b0;
        tests_run++;
        if (descartado !== 1'b1) begin
            tests_failed++; $display("FAIL busy_pulse got %b want 1", descartado);
        end
        @(negedge clk_rapido);
        tests_run++;
        if (descartado !== 1'b0) begin
            tests_failed++; $display("FAIL busy_pulse_end got %b want 0", descartado);
        end
        espera_fim(expirou);
        exp = exp_q.pop_front();
        tests_run++;
        if (expirou || {dez, unid} !== exp) begin
            tests_failed++; $display("FAIL busy_keeps_42 got %b %b timeout %b want %b %b", dez, unid, expirou, exp[13:7], exp[6:0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [13:0] exp;
        bit expirou;
        // pronto is already 1: accept immediately after the previous ATUALIZA
        stdout_7b = LARGURA'(13); stdout_we = 1'b1;
        exp_q.push_back(esperado(13));
        @(negedge clk_rapido);
        stdout_we = 1'b0;
        tests_run++;
        if (pronto !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_accept got pronto %b want 0", pronto);
        end
        espera_fim(expirou);
        exp = exp_q.pop_front();
        tests_run++;
        if (expirou || {dez, unid} !== exp) begin
            tests_failed++; $display("FAIL b2b_13 got %b %b timeout %b want %b %b", dez, unid, expirou, exp[13:7], exp[6:0]);
        end
    endtask

    task automatic test_reset_mid;
        logic [13:0] exp;
        bit expirou;
        escreve(88, 1'b0);
        repeat (2) @(negedge clk_rapido);
        reset = 1'b1;
        @(negedge clk_rapido);
        reset = 1'b0;
        tests_run++;
        if (pronto !== 1'b1 || {dez, unid} !== {7'b1111111, 7'b1111111}) begin
            tests_failed++; $display("FAIL reset_mid got %b %b pronto %b want blank pronto 1", dez, unid, pronto);
        end
        repeat (LARGURA + 2) @(negedge clk_rapido);
        tests_run++;
        if ({dez, unid} !== {7'b1111111, 7'b1111111}) begin
            tests_failed++; $display("FAIL reset_mid_discard got %b %b want blank", dez, unid);
        end
        escreve(5, 1'b1);
        espera_fim(expirou);
        exp = exp_q.pop_front();
        tests_run++;
        if (expirou || {dez, unid} !== exp) begin
            tests_failed++; $display("FAIL after_reset_5 got %b %b timeout %b want %b %b", dez, unid, expirou, exp[13:7], exp[6:0]);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_values();
        test_busy_write();
        test_back_to_back();
        test_reset_mid();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/conversor_display.md
Name: conversor_display

Overview:
- Downstream consumer of the processor's 7-bit stdout value.
- Captures a written value and converts it to BCD with an iterative double-dabble FSM.
- Drives the two active-low 7-segment digits (tens and units) on the board.
- Sits between the CPU's stdout_7b output and the board pins dez_a..g / unid_a..g.

Parameters:
- LARGURA, 7, width of the input value; legal range 4..9; iteration count = LARGURA.

Ports:
- clk_rapido  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- stdout_7b  input  LARGURA  value to display.
- stdout_we  input  1  write strobe; value accepted when stdout_we=1 and pronto=1.
- pronto  output  1  block idle; a write is accepted this cycle.
- descartado  output  1  one-cycle pulse when stdout_we=1 arrives while pronto=0.
- dez_a, dez_b, dez_c, dez_d, dez_e, dez_f, dez_g  output  1 each  tens digit segments, active-low.
- unid_a, unid_b, unid_c, unid_d, unid_e, unid_f, unid_g  output  1 each  units digit segments, active-low.

Behaviour:
- Segment vectors are written {a,b,c,d,e,f,g}; 0 = lit.
- Digit codes:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - traco (dash) = 1111110, apagado (blank) = 1111111
- Reset:
  - FSM goes to OCIOSO; pronto=1; descartado=0.
  - Both digits show apagado.
  - Shift/BCD registers cleared.
- FSM states: OCIOSO, CONVERTE, ATUALIZA.
- OCIOSO:
  - pronto=1.
  - On stdout_we=1: latch stdout_7b into the shift register, clear the 12-bit BCD accumulator, load the iteration counter with LARGURA, go to CONVERTE.
- CONVERTE:
  - Each cycle: add 3 to every BCD nibble >=5, then shift {bcd,shift} left by 1 and decrement the counter.
  - After exactly LARGURA cycles, go to ATUALIZA.
- ATUALIZA (one cycle):
  - If the hundreds nibble is nonzero, both digits show traco.
  - Otherwise tens/units nibbles are decoded into the segment registers.
  - Then go to OCIOSO.
- Latency:
  - Write accepted at edge N (state enters CONVERTE).
  - Segment outputs change at edge N+LARGURA+1.
  - pronto returns to 1 in the same cycle.
- Segment outputs are registered and hold their value until the next ATUALIZA or reset. They never glitch during CONVERTE.
- Busy writes:
  - stdout_we=1 while pronto=0 is ignored and pulses descartado on the next cycle.
  - Conversion continues unaffected.
- Back-to-back writes:
  - A write is accepted on the first cycle pronto=1 after ATUALIZA.
  - Minimum spacing between accepted writes is LARGURA+2 cycles.
- Reset mid-conversion: abort immediately, return to reset state (digits apagado); the partial result is discarded.
- Simultaneous reset and stdout_we: reset wins and the write is dropped.

Optional Feature:
- Macro: APAGA_ZERO_ESQ_EN.
- Defined: in ATUALIZA, when the hundreds nibble is 0 and the tens nibble is 0, the tens digit shows apagado (leading-zero blanking). Units is always shown.
- Undefined: tens always shows its digit, including 0.
- Overflow dash behaviour is identical in both builds.

Decomposition:
- Package display_pkg holds:
  - state enum estado_t {OCIOSO, CONVERTE, ATUALIZA}
  - constants SEG_APAGADO, SEG_TRACO, and the ten digit codes
  - function for the add-3 nibble correction
- One natural sub-module: decod_7seg (4-bit BCD in, 7-bit active-low segments out; codes >9 give apagado). Instantiated twice, for tens and units.
- FSM and datapath stay in conversor_display.

Test Plan:
- Reset, then idle 20 cycles -> pronto=1, dez=1111111, unid=1111111, descartado=0.
- Write 42 -> outputs unchanged for LARGURA cycles, then dez=1001100, unid=0010010 at edge N+8; pronto=1 that cycle.
- Write 7 -> dez=0000001, unid=0001111 (macro off); dez=1111111, unid=0001111 (APAGA_ZERO_ESQ_EN on). Write 99 -> dez=unid=0000100. Write 0 -> dez=unid=0000001 (macro off).
- Write 100, then 127 -> dez=unid=1111110 after each conversion.
- Write 42, then strobe 13 two cycles later -> descartado pulses once, final display 42. Then write 13 once pronto=1 -> display dez=1001111, unid=0000110.
- Write 88, assert reset at cycle 3 of CONVERTE -> digits apagado, pronto=1 next cycle. Then write 5 -> unid=0100100.
